// File: rtl/cond_unit.sv
// Condition/flag stage after the ALU: holds NZCV, evaluates the condition field
// against the held flags, and gates the decoder's write strobes.
module cond_unit #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       En,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       NoWrite,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic n, z, c, v;
  logic upd;

  assign {n, z, c, v} = Flags;

  // Condition is judged on the registered flags only; a flag-setting op
  // influences the following instruction, never itself.
  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = (n == v);
      4'b1011: CondEx = (n != v);
      4'b1100: CondEx = ~z & (n == v);
      4'b1101: CondEx = z | (n != v);
      default: CondEx = 1'b1;
    endcase
  end

  assign upd      = En & CondEx;
  assign PCSrc    = PCS & upd;
  assign RegWrite = RegW & ~NoWrite & upd;
  assign MemWrite = MemW & upd;

  // N,Z and C,V halves are written independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= FLAG_RST;
    end else if (upd) begin
      if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule
